// File: rtl/turbo_encoder_core_pkg.sv
// Shared definitions for the runtime-configurable LTE turbo encoder:
// FSM encoding, block-size limits and constituent generator taps.
package turbo_pkg;

   localparam int K_MAX_DEF = 6144;
   localparam int K_MIN_DEF = 40;

   // Tap masks over the constituent state {s2, s1, s0}
   localparam logic [2:0] G0_TAPS = 3'b110;
   localparam logic [2:0] G1_TAPS = 3'b101;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENCODE = 3'd1,
      TERM   = 3'd2,
      TAIL   = 3'd3
   } enc_state_t;

endpackage

// File: rtl/turbo_encoder_core_if.sv
// Handshake bundle between the interleaver front-end, the encoder core
// and the rate-matching stage.
interface turbo_encoder_core_if #(
   parameter int KW = 13
);
   logic          start;
   logic [KW-1:0] blk_k;
   logic          in_valid;
   logic          sys_bit;
   logic          int_bit;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic          d0;
   logic          d1;
   logic          d2;
   logic          out_last;

   modport master (
      output start, blk_k, in_valid, sys_bit, int_bit, out_ready,
      input  in_ready, out_valid, d0, d1, d2, out_last
   );

   modport slave (
      input  start, blk_k, in_valid, sys_bit, int_bit, out_ready,
      output in_ready, out_valid, d0, d1, d2, out_last
   );
endinterface

// File: rtl/turbo_encoder_core_rsc.sv
// Recursive systematic convolutional constituent (g0 = 1+D^2+D^3,
// g1 = 1+D+D^3) with trellis-termination mode.
module rsc_encoder
   import turbo_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       u,
   input  logic       en,
   input  logic       term,
   input  logic       clr,
   output logic       x,
   output logic       z,
   output logic [2:0] s
);

   logic fb;
   logic a;

   // During termination the input equals the feedback, forcing a = 0
   always_comb begin
      fb = ^(s & G0_TAPS);
      x  = term ? fb : u;
      a  = x ^ fb;
      z  = a ^ (^(s & G1_TAPS));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s <= '0;
      end else if (clr) begin
         s <= '0;
      end else if (en) begin
         s <= {s[1:0], a};
      end
   end

endmodule

// File: rtl/turbo_encoder_core.sv
// Turbo encoder core: two RSC constituents, 3-step termination and a
// four-triple tail, with valid/ready flow control on both sides.
module turbo_encoder_core
   import turbo_pkg::*;
#(
   parameter int K_MAX = K_MAX_DEF,
   parameter int K_MIN = K_MIN_DEF,
   parameter int KW    = $clog2(K_MAX + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   turbo_encoder_core_if.slave  bus,
   output logic                 busy,
   output logic                 cfg_err,
   output logic [2:0]           state
);

   enc_state_t    cur_st;
   enc_state_t    nxt_st;
   logic [KW-1:0] k_reg;
   logic [KW-1:0] count;
   logic [1:0]    term_cnt;
   logic [2:0]    tail_cnt;
   logic [2:0]    tx1, tz1, tx2, tz2;
   logic          d0_q, d1_q, d2_q, valid_q, last_q;
   logic          k_ok, start_ok, in_ready, in_fire, tail_load, last_fire;
   logic          rsc_en, rsc_term;
   logic          x1, z1, x2, z2;
   logic [2:0]    s1, s2;
   logic [5:0]    rsc_state_unused;

   assign rsc_state_unused = {s1, s2};

   rsc_encoder u_rsc1 (
      .clock(clock), .reset(reset), .u(bus.sys_bit), .en(rsc_en),
      .term(rsc_term), .clr(start_ok), .x(x1), .z(z1), .s(s1)
   );

   rsc_encoder u_rsc2 (
      .clock(clock), .reset(reset), .u(bus.int_bit), .en(rsc_en),
      .term(rsc_term), .clr(start_ok), .x(x2), .z(z2), .s(s2)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur_st <= IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   // Next state plus handshake and constituent control strobes
   always_comb begin
      nxt_st    = cur_st;
      k_ok      = (bus.blk_k >= KW'(K_MIN)) && (bus.blk_k <= KW'(K_MAX));
      start_ok  = (cur_st == IDLE) && bus.start && k_ok;
      in_ready  = (cur_st == ENCODE) && (!valid_q || bus.out_ready);
      in_fire   = in_ready && bus.in_valid;
      rsc_term  = (cur_st == TERM);
      rsc_en    = in_fire || rsc_term;
      tail_load = (cur_st == TAIL) && (tail_cnt < 3'd4) && (!valid_q || bus.out_ready);
      last_fire = (cur_st == TAIL) && valid_q && last_q && bus.out_ready;
      case (cur_st)
         IDLE:    if (start_ok) nxt_st = ENCODE;
         ENCODE:  if (in_fire && (count == k_reg - 1'b1)) nxt_st = TERM;
         TERM:    if (term_cnt == 2'd2) nxt_st = TAIL;
         TAIL:    if (last_fire) nxt_st = IDLE;
         default: nxt_st = IDLE;
      endcase
   end

   // Block bookkeeping, tail capture and the output holding register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         k_reg    <= '0;
         count    <= '0;
         term_cnt <= '0;
         tail_cnt <= '0;
         tx1      <= '0;
         tz1      <= '0;
         tx2      <= '0;
         tz2      <= '0;
         d0_q     <= 1'b0;
         d1_q     <= 1'b0;
         d2_q     <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= (cur_st == IDLE) && bus.start && !k_ok;
         if (start_ok) begin
            k_reg    <= bus.blk_k;
            count    <= '0;
            term_cnt <= '0;
            tail_cnt <= '0;
         end
         if (in_fire) begin
            count <= count + 1'b1;
         end
         if (rsc_term) begin
            tx1[term_cnt] <= x1;
            tz1[term_cnt] <= z1;
            tx2[term_cnt] <= x2;
            tz2[term_cnt] <= z2;
            term_cnt      <= term_cnt + 2'd1;
         end
         if (in_fire) begin
            d0_q    <= bus.sys_bit;
            d1_q    <= z1;
            d2_q    <= z2;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
         end else if (tail_load) begin
            case (tail_cnt[1:0])
               2'd0:    {d0_q, d1_q, d2_q} <= {tx1[0], tz1[0], tx1[1]};
               2'd1:    {d0_q, d1_q, d2_q} <= {tz1[1], tx1[2], tz1[2]};
               2'd2:    {d0_q, d1_q, d2_q} <= {tx2[0], tz2[0], tx2[1]};
               default: {d0_q, d1_q, d2_q} <= {tz2[1], tx2[2], tz2[2]};
            endcase
            valid_q  <= 1'b1;
            last_q   <= (tail_cnt == 3'd3);
            tail_cnt <= tail_cnt + 3'd1;
         end else if (bus.out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.d0        = d0_q;
   assign bus.d1        = d1_q;
   assign bus.d2        = d2_q;
   assign bus.out_last  = last_q;
   assign busy          = (cur_st != IDLE);
   assign state         = cur_st;

endmodule

// File: tb/tb_turbo_encoder_core.sv
// Scoreboard bench for turbo_encoder_core: directed blocks, hand-derived
// impulse/tail values, config errors, backpressure and mid-block reset.
module tb_turbo_encoder_core;

   localparam int KW = 13;

   typedef struct packed {
      logic d0;
      logic d1;
      logic d2;
      logic last;
   } trip_t;

   logic       clock;
   logic       reset;
   logic       busy;
   logic       cfg_err;
   logic [2:0] state;

   turbo_encoder_core_if #(.KW(KW)) bus ();

   turbo_encoder_core dut (
      .clock(clock), .reset(reset), .bus(bus),
      .busy(busy), .cfg_err(cfg_err), .state(state)
   );

   trip_t sb_q[$];
   trip_t rx_log[$];
   int    n_vec;
   int    n_err;
   int    rx_count;
   bit    rand_ready;
   logic  sys_v[0:6143];
   logic  int_v[0:6143];
   logic [2:0] m1, m2;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference constituent: a is the new register bit, x the transmitted input
   task automatic model_step(input logic [2:0] st, input logic u,
                             output logic [2:0] nst, output logic z);
      logic a;
      a   = u ^ st[1] ^ st[2];
      z   = a ^ st[0] ^ st[2];
      nst = {st[1:0], a};
   endtask

   task automatic push_tail();
      logic [2:0] tx_a, tz_a, tx_b, tz_b;
      logic       u, z;
      for (int i = 0; i < 3; i++) begin
         u = m1[1] ^ m1[2];
         tx_a[i] = u;
         model_step(m1, u, m1, z);
         tz_a[i] = z;
         u = m2[1] ^ m2[2];
         tx_b[i] = u;
         model_step(m2, u, m2, z);
         tz_b[i] = z;
      end
      sb_q.push_back({tx_a[0], tz_a[0], tx_a[1], 1'b0});
      sb_q.push_back({tz_a[1], tx_a[2], tz_a[2], 1'b0});
      sb_q.push_back({tx_b[0], tz_b[0], tx_b[1], 1'b0});
      sb_q.push_back({tz_b[1], tx_b[2], tz_b[2], 1'b1});
   endtask

   // Caller is aligned one step after a rising edge; start is raised at once
   task automatic applyStimulus(input int k, input int n_feed);
      int   idx;
      int   cyc;
      int   rx0;
      bit   fire;
      logic za, zb;
      rx0 = rx_count;
      bus.start = 1'b1;
      bus.blk_k = KW'(k);
      @(posedge clock); #1;
      bus.start = 1'b0;
      checkOutput("busy_on_start", busy, 1'b1);
      m1  = '0;
      m2  = '0;
      idx = 0;
      cyc = 0;
      while (idx < n_feed && cyc < 40000) begin
         bus.in_valid = 1'b1;
         bus.sys_bit  = sys_v[idx];
         bus.int_bit  = int_v[idx];
         @(negedge clock);
         fire = bus.in_ready;
         if (fire) begin
            model_step(m1, sys_v[idx], m1, za);
            model_step(m2, int_v[idx], m2, zb);
            sb_q.push_back({sys_v[idx], za, zb, 1'b0});
         end
         @(posedge clock); #1;
         if (fire) idx++;
         cyc++;
      end
      bus.in_valid = 1'b0;
      if (idx < n_feed) begin
         checkOutput("feed_timeout", idx, n_feed);
      end
      if (n_feed == k) begin
         push_tail();
         cyc = 0;
         while (busy && cyc < 40000) begin
            @(posedge clock); #1;
            cyc++;
         end
         checkOutput("busy_fall", busy, 1'b0);
         checkOutput("sb_drained", sb_q.size(), 0);
         checkOutput("triple_count", rx_count - rx0, k + 4);
      end
   endtask

   always @(posedge clock) begin
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 9) >= 3);
      else            bus.out_ready = 1'b1;
   end

   // Monitor: pops and compares every accepted triple
   always @(negedge clock) begin
      trip_t act;
      trip_t exp;
      if (reset && bus.out_valid && !bus.out_ready && bus.in_ready) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL in_ready_protocol: got in_ready=1 expected 0 while stalled");
      end
      if (reset && bus.out_valid && bus.out_ready) begin
         act = {bus.d0, bus.d1, bus.d2, bus.out_last};
         rx_log.push_back(act);
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL unexpected_triple: got %0h expected none", act);
         end else begin
            exp = sb_q.pop_front();
            checkOutput($sformatf("triple%0d", rx_count), act, exp);
         end
         rx_count++;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_vec = 0; n_err = 0; rx_count = 0; rand_ready = 1'b0;
      reset = 1'b0;
      bus.start = 1'b0; bus.blk_k = '0; bus.in_valid = 1'b0;
      bus.sys_bit = 1'b0; bus.int_bit = 1'b0; bus.out_ready = 1'b1;
      #1;
      checkOutput("reset_outputs",
                  {bus.out_valid, bus.d0, bus.d1, bus.d2, bus.out_last, bus.in_ready},
                  6'b0);
      checkOutput("reset_busy_cfg", {busy, cfg_err}, 2'b00);
      checkOutput("reset_state", state, 3'd0);
      #20;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      $display("[TB] K=40 all-zero block");
      for (int i = 0; i < 40; i++) begin sys_v[i] = 1'b0; int_v[i] = 1'b0; end
      applyStimulus(40, 40);

      $display("[TB] K=40 systematic impulse");
      sys_v[0] = 1'b1;
      rx_log.delete();
      applyStimulus(40, 40);
      checkOutput("impulse_count", rx_log.size(), 44);
      if (rx_log.size() == 44) begin
         checkOutput("impulse_t0", rx_log[0], 4'b1100);
         checkOutput("impulse_t1", rx_log[1], 4'b0100);
         checkOutput("impulse_t2", rx_log[2], 4'b0100);
         checkOutput("impulse_tail0", rx_log[40], 4'b0000);
         checkOutput("impulse_tail1", rx_log[41], 4'b1110);
         checkOutput("impulse_tail2", rx_log[42], 4'b0000);
         checkOutput("impulse_tail3", rx_log[43], 4'b0001);
      end

      $display("[TB] invalid block sizes");
      for (int t = 0; t < 2; t++) begin
         bus.start = 1'b1;
         bus.blk_k = (t == 0) ? KW'(39) : KW'(6145);
         @(posedge clock); #1;
         bus.start = 1'b0;
         checkOutput($sformatf("cfg_err_pulse%0d", t), cfg_err, 1'b1);
         checkOutput($sformatf("cfg_err_idle%0d", t), {busy, state}, 4'b0000);
         @(posedge clock); #1;
         checkOutput($sformatf("cfg_err_clear%0d", t), cfg_err, 1'b0);
      end

      $display("[TB] K=6144 random with backpressure");
      for (int i = 0; i < 6144; i++) begin
         sys_v[i] = 1'($urandom_range(0, 1));
         int_v[i] = 1'($urandom_range(0, 1));
      end
      rand_ready = 1'b1;
      applyStimulus(6144, 6144);

      $display("[TB] reset in the middle of a K=512 block");
      applyStimulus(512, 100);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  {bus.out_valid, bus.d0, bus.d1, bus.d2, bus.out_last, bus.in_ready},
                  6'b0);
      checkOutput("midreset_state", {busy, cfg_err, state}, 5'b0);
      sb_q.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 512; i++) begin
         sys_v[i] = 1'($urandom_range(0, 1));
         int_v[i] = 1'($urandom_range(0, 1));
      end
      applyStimulus(512, 512);

      $display("[TB] back-to-back K=40 blocks");
      rand_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 40; i++) begin
            sys_v[i] = 1'($urandom_range(0, 1));
            int_v[i] = 1'($urandom_range(0, 1));
         end
         applyStimulus(40, 40);
      end

      repeat (4) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/turbo_encoder_core.md
Name: turbo_encoder_core

Overview:
- Runtime-configurable successor to the two-mode LTE turbo encoder top.
- Accepts any block size K from 40 to K_MAX instead of only 1056/6144.
- Encodes paired systematic/interleaved bit streams through two 3GPP 36.212 RSC constituents, then appends the 12-bit trellis termination.
- Full valid/ready backpressure on both sides; sits between the CRC/segmentation FIFO plus interleaver and the rate-matching stage.

Parameters:
- K_MAX, 6144, largest accepted block size in bits.
- K_MIN, 40, smallest accepted block size in bits.
- KW, $clog2(K_MAX+1), width of the blk_k input and the internal bit counter.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- start  in  1  one-cycle request to begin a block; sampled only in IDLE.
- blk_k  in  KW  block size K; sampled together with start.
- in_valid  in  1  sys_bit and int_bit are both valid.
- sys_bit  in  1  systematic bit c_k.
- int_bit  in  1  interleaved bit c'_k, aligned with sys_bit.
- in_ready  out  1  core accepts the input pair this cycle.
- out_valid  out  1  d0/d1/d2 hold a valid triple.
- out_ready  in  1  downstream accepts the triple.
- d0, d1, d2  out  1 each  output streams: x_k, z_k, z'_k during data; tail mapping during termination.
- out_last  out  1  marks the final (K+4)th triple.
- busy  out  1  high from start acceptance until the last triple is accepted.
- cfg_err  out  1  one-cycle pulse when start arrives with an invalid K.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset values: state=IDLE, all outputs 0, counter 0, both RSC registers 000.
- FSM states and transitions:
  - IDLE(0): on start with K_MIN<=blk_k<=K_MAX, latch K, clear both RSCs, go to ENCODE, set busy. On start with any other blk_k, pulse cfg_err and stay in IDLE.
  - ENCODE(1): in_ready = ~out_valid | out_ready. An input pair is accepted when in_valid & in_ready.
  - After K accepted pairs, go to TERM(2). in_ready is 0 from that point.
  - TERM(2): 3 cycles, internal only, no output. Both RSCs run simultaneously with the feedback switch closed. The x and z of each step are captured into tail registers tx[0..2], tz[0..2] for RSC1 and tx'[0..2], tz'[0..2] for RSC2. Then go to TAIL(3).
  - TAIL(3): emit 4 triples, each held until out_ready:
    - j=0: (tx0, tz0, tx1)
    - j=1: (tz1, tx2, tz2)
    - j=2: (tx'0, tz'0, tx'1)
    - j=3: (tz'1, tx'2, tz'2), with out_last=1.
  - When the last triple is accepted, return to IDLE and clear busy.
- RSC arithmetic, per encoder, state s[2:0] with s0 newest:
  - a = u^s1^s2 (g0 = 1+D^2+D^3)
  - z = a^s0^s2 (g1 = 1+D+D^3)
  - next s = {s1, s0, a}
  - Termination: u = s1^s2, so a = 0. Captured x = u, z = s0^s2.
- Latency: data triple k = (sys_bit_k, z_k, z'_k) is registered and appears 1 cycle after its input pair is accepted.
- Output register: holds the triple stable while out_valid & ~out_ready. Never drops or duplicates a triple.
- Bit counter: KW wide. Increments on each accepted pair; ENCODE exits when count == K-1 is accepted. No wrap-around is reachable.
- start outside IDLE is ignored; cfg_err is not raised.
- Back-to-back blocks: start is accepted in the cycle after the out_last handshake.
- Reset asserted mid-block: immediate return to IDLE with all state cleared. The partial block is discarded and no out_last is produced.
- in_valid while in TERM, TAIL or IDLE: no effect.

Decomposition:
- Shared package turbo_pkg:
  - State encoding constants IDLE/ENCODE/TERM/TAIL.
  - K_MIN and K_MAX defaults.
  - Generator tap constants.
- Sub-module rsc_encoder: inputs u, en, term, clr; outputs x, z and the 3-bit state. Instantiated twice.
- Tail capture/emit logic and the FSM live in the top.

Test Plan:
- K=40, all-zero sys and int, out_ready=1 -> exactly 44 triples, all (0,0,0); out_last on triple 43 only; busy falls after it.
- K=40, sys_bit0=1, all other bits 0, int all 0 -> triples 0..2 = (1,1,0), (0,1,0), (0,1,0). Full stream plus 4 tail triples matches the golden C model.
- K=6144, random bits, random out_ready at 30% low -> 6148 triples bit-exact vs model; in_ready never high while out_valid & ~out_ready.
- start with blk_k=39, then with blk_k=6145 -> cfg_err pulse each time, busy=0, state=0. Then blk_k=6144 is accepted.
- Reset driven low after 100 of 512 bits -> all outputs 0 asynchronously. A new K=512 block afterwards matches the model with no residual RSC state.
- Two K=40 blocks with start in the cycle after out_last -> 88 triples total; each block's tail matches an independent encode.
